serial_add_ctrl: RTL

Sequencer for the bit-serial adder. It accepts two parallel WIDTH-bit operands through a start/ready handshake, clears the adder, and streams the operands LSB-first into it. It collects the serial sum bits back into a parallel word and reports the final carry with a one-cycle done pulse. It sits between a parallel requester and one serial adder instance with registered sum/carry outputs.

---
 rtl/serial_add_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Sequencer for a bit-serial adder: accepts parallel operands,
//            streams them LSB-first, reassembles the sum and final carry.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             add_rst,
    output logic             add_a,
    output logic             add_b,
    input  logic             add_f,
    input  logic             add_cout
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_sum_sr;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_last;

    assign w_last = (r_cnt == c_CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_cnt    <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr <= a_in;
                        r_b_sr <= b_in;
                    end
                end
                S_CLEAR: begin
                    r_cnt <= '0;
                end
                S_SHIFT: begin
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_cnt  <= r_cnt + c_CNT_W'(1);
                    // add_f lags the applied bits by one cycle, so nothing is valid at cnt=0
                    if (r_cnt != '0) begin
                        r_sum_sr <= {add_f, r_sum_sr[WIDTH-1:1]};
                    end
                end
                S_DRAIN: begin
                    sum_out  <= {add_f, r_sum_sr[WIDTH-1:1]};
                    cout_out <= add_cout;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next  = S_IDLE;
        ready   = 1'b0;
        done    = 1'b0;
        add_rst = 1'b0;
        add_a   = 1'b0;
        add_b   = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready   = 1'b1;
                add_rst = 1'b1;
                w_next  = start ? S_CLEAR : S_IDLE;
            end
            S_CLEAR: begin
                add_rst = 1'b1;
                w_next  = S_SHIFT;
            end
            S_SHIFT: begin
                add_a  = r_a_sr[0];
                add_b  = r_b_sr[0];
                w_next = w_last ? S_DRAIN : S_SHIFT;
            end
            S_DRAIN: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Hold the adder cleared for as long as reset is asserted
        if (!rst) begin
            add_rst = 1'b1;
        end
    end

    assign busy = ~ready;

endmodule
`default_nettype wire
